// File: rtl/w2upd_pkg.sv
// ---------------------------------------------------------------------------
// w2upd_pkg
// Shared definitions for the hidden-layer weight/bias update stage:
//   DW, FRAC     : Q6.10 data width and fractional bit count
//   QMAX, QMIN   : Q6.10 saturation limits
//   state_e      : update FSM states
//   qSub         : DW-bit subtraction, wrapping by default, saturating when
//                  the W2UPD_SAT_EN macro is defined
// ---------------------------------------------------------------------------
package w2upd_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 10;

  localparam logic [DW-1:0] QMAX = 16'h7FFF;
  localparam logic [DW-1:0] QMIN = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WRITE,
    BCALC,
    BWRITE,
    DONE
  } state_e;

  // Signed a - b. The saturating variant widens by one bit so the true
  // difference is visible, then clamps when the top two bits disagree.
  function automatic logic [DW-1:0] qSub(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
`ifdef W2UPD_SAT_EN
    logic [DW:0] diff;
    diff = {a[DW-1], a} - {b[DW-1], b};
    if (diff[DW] != diff[DW-1]) begin
      return diff[DW] ? QMIN : QMAX;
    end
    return diff[DW-1:0];
`else
    return a - b;
`endif
  endfunction

endpackage

// File: rtl/fxp_mul_q6_10.sv
// ---------------------------------------------------------------------------
// fxp_mul_q6_10
// Signed Q6.10 multiply: full DWxDW product, then the [FRAC+DW-1:FRAC] slice,
// which is an arithmetic (floor) truncation. With W2UPD_SAT_EN defined the
// slice saturates to QMAX/QMIN when the product does not fit in DW bits;
// otherwise it wraps.
// Ports:
//   a_i  in  DW  signed operand
//   b_i  in  DW  signed operand
//   y_o  out DW  signed Q6.10 product
// ---------------------------------------------------------------------------
module fxp_mul_q6_10 #(
  parameter int DW   = 16,
  parameter int FRAC = 10
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] y_o
);
  import w2upd_pkg::*;

  logic signed [2*DW-1:0] prod;

  assign prod = a_i * b_i;

`ifdef W2UPD_SAT_EN
  // The slice only represents the product when every bit above it matches
  // the slice's own sign bit.
  logic ovf;
  logic unused_lowBits;

  assign ovf = (prod[2*DW-1:FRAC+DW-1] != {(DW-FRAC+1){prod[2*DW-1]}});
  assign y_o = ovf ? (prod[2*DW-1] ? QMIN : QMAX) : prod[FRAC+DW-1:FRAC];
  assign unused_lowBits = ^prod[FRAC-1:0];
`else
  logic unused_dropBits;

  assign y_o = prod[FRAC+DW-1:FRAC];
  assign unused_dropBits = ^{prod[2*DW-1:FRAC+DW], prod[FRAC-1:0]};
`endif

endmodule

// File: rtl/w2_update_module.sv
// ---------------------------------------------------------------------------
// w2_update_module
// Hidden-layer weight/bias update stage. On the rising edge of the update
// trigger (step != 0 and controller == 9) it snapshots delta2, lr, a, w, b
// and streams w[i] - lr*(delta2*a[i]) for every input, then b - lr*delta2,
// over a valid/ready write port.
// Configuration macro: W2UPD_SAT_EN (saturating arithmetic instead of wrap).
// Ports:
//   clk         in   clock, posedge
//   rst         in   synchronous reset, active-low
//   controller  in   training phase, 9 = update
//   step        in   training step, 0 = inference (never updates)
//   delta2      in   hidden-neuron error, Q6.10
//   lr          in   learning rate, Q6.10
//   a_in        in   activations, element i at [i*DW +: DW]
//   w_in        in   current weights, same packing
//   b_in        in   current bias
//   wr_valid    out  write beat valid
//   wr_ready    in   weight store accepts beat
//   wr_addr     out  weight index (0 for the bias beat)
//   wr_is_bias  out  beat carries the bias
//   wr_data     out  updated value, Q6.10
//   busy        out  high from first CALC until DONE inclusive
//   done        out  one-cycle pulse after the bias beat is accepted
// ---------------------------------------------------------------------------
module w2_update_module #(
  parameter int N_IN = 4,
  parameter int DW   = 16,
  parameter int FRAC = 10,
  parameter int AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           controller,
  input  logic [3:0]           step,
  input  logic [DW-1:0]        delta2,
  input  logic [DW-1:0]        lr,
  input  logic [N_IN*DW-1:0]   a_in,
  input  logic [N_IN*DW-1:0]   w_in,
  input  logic [DW-1:0]        b_in,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [AW-1:0]        wr_addr,
  output logic                 wr_is_bias,
  output logic [DW-1:0]        wr_data,
  output logic                 busy,
  output logic                 done
);
  import w2upd_pkg::*;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                trig_q;
  logic [DW-1:0]       delta2_q, lr_q, b_q, result_q;
  logic [N_IN*DW-1:0]  a_q, w_q;

  logic                trig, startPulse;
  logic [DW-1:0]       aSel, wSel, gVal, sOpA, sVal, minuend;

  assign trig       = (step != 4'd0) && (controller == 4'd9);
  assign startPulse = trig && !trig_q;

  assign aSel = a_q[idx_q*DW +: DW];
  assign wSel = w_q[idx_q*DW +: DW];

  // The second multiplier computes g*lr for weights and delta2*lr for the
  // bias, so BCALC only needs to swap its first operand and the minuend.
  assign sOpA    = (state_q == BCALC) ? delta2_q : gVal;
  assign minuend = (state_q == BCALC) ? b_q : wSel;

  fxp_mul_q6_10 #(.DW(DW), .FRAC(FRAC)) u_gMul (
    .a_i (delta2_q),
    .b_i (aSel),
    .y_o (gVal)
  );

  fxp_mul_q6_10 #(.DW(DW), .FRAC(FRAC)) u_sMul (
    .a_i (sOpA),
    .b_i (lr_q),
    .y_o (sVal)
  );

  // Next-state logic; a beat only advances the sequence once accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (startPulse) begin
          state_d = CALC;
          idx_d   = '0;
        end
      end
      CALC:  state_d = WRITE;
      WRITE: begin
        if (wr_ready) begin
          if (idx_q == AW'(N_IN-1)) begin
            state_d = BCALC;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = CALC;
          end
        end
      end
      BCALC:  state_d = BWRITE;
      BWRITE: begin
        if (wr_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, trigger history, snapshots and the result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      trig_q   <= 1'b0;
      delta2_q <= '0;
      lr_q     <= '0;
      b_q      <= '0;
      a_q      <= '0;
      w_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      trig_q  <= trig;
      if ((state_q == IDLE) && startPulse) begin
        delta2_q <= delta2;
        lr_q     <= lr;
        b_q      <= b_in;
        a_q      <= a_in;
        w_q      <= w_in;
      end
      if ((state_q == CALC) || (state_q == BCALC)) begin
        result_q <= qSub(minuend, sVal);
      end
    end
  end

  // Outputs are decoded from registered state so they are glitch-free and
  // stay stable for the whole of a stalled beat.
  always_comb begin
    wr_valid   = (state_q == WRITE) || (state_q == BWRITE);
    wr_is_bias = (state_q == BWRITE);
    wr_addr    = (state_q == WRITE) ? idx_q : '0;
    wr_data    = wr_valid ? result_q : '0;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_w2_update_module.sv
// ---------------------------------------------------------------------------
// tb_w2_update_module
// Scoreboard bench for w2_update_module. Stimulus pushes expected beats into
// a queue; a negedge monitor pops and compares every accepted write beat,
// and also checks that stalled beats hold steady.
// ---------------------------------------------------------------------------
module tb_w2_update_module;

  localparam int N_IN = 4;
  localparam int DW   = 16;

  typedef struct packed {
    logic [1:0]  addr;
    logic        isBias;
    logic [15:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        controller = 4'd0;
  logic [3:0]        step = 4'd0;
  logic [DW-1:0]     delta2 = '0;
  logic [DW-1:0]     lr = '0;
  logic [N_IN*DW-1:0] a_in = '0;
  logic [N_IN*DW-1:0] w_in = '0;
  logic [DW-1:0]     b_in = '0;
  logic              wr_ready = 1'b1;
  logic              wr_valid;
  logic [1:0]        wr_addr;
  logic              wr_is_bias;
  logic [DW-1:0]     wr_data;
  logic              busy;
  logic              done;

  w2_update_module #(.N_IN(N_IN), .DW(DW), .FRAC(10), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .controller (controller),
    .step       (step),
    .delta2     (delta2),
    .lr         (lr),
    .a_in       (a_in),
    .w_in       (w_in),
    .b_in       (b_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_is_bias (wr_is_bias),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int    checks = 0;
  int    errors = 0;
  int    startK = 0;
  int    beatCnt = 0;
  int    doneCnt = 0;
  int    lastDoneRel = 0;
  beat_t expQ[$];
  int    acceptCycQ[$];
  bit    pendValid = 0;
  beat_t pendBeat;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: plain integer math on the Q6.10 values.
  function automatic logic [15:0] mulQ(input logic [15:0] x, input logic [15:0] y);
    longint p, q;
    p = longint'($signed(x)) * longint'($signed(y));
    q = p >>> 10;
`ifdef W2UPD_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  function automatic logic [15:0] subQ(input logic [15:0] x, input logic [15:0] y);
    longint r;
    r = longint'($signed(x)) - longint'($signed(y));
`ifdef W2UPD_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic pushBeat(input int addr, input bit isBias, input logic [15:0] data);
    beat_t e;
    e.addr   = 2'(addr);
    e.isBias = isBias;
    e.data   = data;
    expQ.push_back(e);
  endtask

  task automatic pushModel(input logic [15:0] d, input logic [15:0] l,
                           input logic [N_IN*DW-1:0] a, input logic [N_IN*DW-1:0] w,
                           input logic [15:0] b);
    for (int i = 0; i < N_IN; i++) begin
      pushBeat(i, 1'b0, subQ(w[i*DW +: DW], mulQ(mulQ(d, a[i*DW +: DW]), l)));
    end
    pushBeat(0, 1'b1, subQ(b, mulQ(d, l)));
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] l,
                               input logic [N_IN*DW-1:0] a, input logic [N_IN*DW-1:0] w,
                               input logic [15:0] b);
    @(posedge clk); #1;
    delta2     = d;
    lr         = l;
    a_in       = a;
    w_in       = w;
    b_in       = b;
    step       = 4'd1;
    controller = 4'd9;
    startK     = cyc;
  endtask

  // mode 0: ready high; 1: ready low in cycles 4..6; 2: random ready,
  // scrambled inputs and controller toggling (retriggers while busy).
  task automatic runOp(input int mode);
    int d0;
    bit finished;
    int rel;
    d0 = doneCnt;
    finished = 0;
    for (int n = 0; n < 150 && !finished; n++) begin
      @(posedge clk); #1;
      controller = 4'd8;
      rel = cyc - startK;
      if (doneCnt != d0) begin
        finished = 1;
      end else if (mode == 0) begin
        wr_ready = 1'b1;
      end else if (mode == 1) begin
        wr_ready = !(rel >= 4 && rel <= 6);
      end else begin
        wr_ready   = ($urandom_range(0, 2) != 0);
        controller = ($urandom_range(0, 1) != 0) ? 4'd9 : 4'd8;
        delta2     = 16'($urandom);
        lr         = 16'($urandom);
        b_in       = 16'($urandom);
        a_in       = {$urandom, $urandom};
        w_in       = {$urandom, $urandom};
      end
    end
    wr_ready   = 1'b1;
    controller = 4'd0;
    checkOutput("op_completed", 32'(finished), 32'd1);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: every accepted beat is popped and compared; a stalled beat must
  // stay identical until accepted.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (!rst) begin
      pendValid = 0;
    end else begin
      cur.addr   = wr_addr;
      cur.isBias = wr_is_bias;
      cur.data   = wr_data;
      if (wr_valid) begin
        if (pendValid) checkOutput("hold_stable", 32'(cur), 32'(pendBeat));
        if (wr_ready) begin
          acceptCycQ.push_back(cyc - startK);
          beatCnt++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got 0x%0h, expected none", 32'(cur));
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_data", 32'(wr_data), 32'(e.data));
            checkOutput("beat_addr", 32'(wr_addr), 32'(e.addr));
            checkOutput("beat_is_bias", 32'(wr_is_bias), 32'(e.isBias));
          end
          pendValid = 0;
        end else begin
          pendValid = 1;
          pendBeat  = cur;
        end
      end else if (pendValid) begin
        checks++;
        errors++;
        $display("[TB] FAIL valid_dropped: got 0, expected 1");
        pendValid = 0;
      end
      if (done) begin
        doneCnt++;
        lastDoneRel = cyc - startK;
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [N_IN*DW-1:0] A1 = 64'h0000_0000_0000_0400;
  localparam logic [N_IN*DW-1:0] W1 = 64'h0000_0000_0000_0400;
  localparam logic [N_IN*DW-1:0] W4 = 64'h0000_0000_0000_8000;

  initial begin
    int cycBasic[5];
    int cycStall[5];
    int b0, d0;
    cycBasic = '{2, 4, 6, 8, 10};
    cycStall = '{2, 7, 9, 11, 13};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_is_bias", 32'(wr_is_bias), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    controller = 4'd8;
    repeat (2) @(posedge clk);

    // Basic sequence with timing
    $display("[TB] basic update");
    acceptCycQ.delete();
    applyStimulus(16'h0200, 16'h0100, A1, W1, 16'h0000);
    pushBeat(0, 0, 16'h0380); pushBeat(1, 0, 16'h0000);
    pushBeat(2, 0, 16'h0000); pushBeat(3, 0, 16'h0000);
    pushBeat(0, 1, 16'hFF80);
    runOp(0);
    for (int j = 0; j < 5; j++) checkOutput($sformatf("basic_beat%0d_cycle", j), 32'(acceptCycQ[j]), 32'(cycBasic[j]));
    checkOutput("basic_done_cycle", 32'(lastDoneRel), 32'd11);

    // Backpressure on the w1 beat
    $display("[TB] backpressure");
    acceptCycQ.delete();
    applyStimulus(16'h0200, 16'h0100, A1, W1, 16'h0000);
    pushBeat(0, 0, 16'h0380); pushBeat(1, 0, 16'h0000);
    pushBeat(2, 0, 16'h0000); pushBeat(3, 0, 16'h0000);
    pushBeat(0, 1, 16'hFF80);
    runOp(1);
    for (int j = 0; j < 5; j++) checkOutput($sformatf("stall_beat%0d_cycle", j), 32'(acceptCycQ[j]), 32'(cycStall[j]));
    checkOutput("stall_done_cycle", 32'(lastDoneRel), 32'd14);

    // Gating: inference step never triggers; held trigger fires once
    $display("[TB] gating");
    @(posedge clk); #1;
    step = 4'd0;
    controller = 4'd9;
    repeat (5) begin
      @(negedge clk);
      checkOutput("gate_busy", 32'(busy), 32'd0);
      checkOutput("gate_wr_valid", 32'(wr_valid), 32'd0);
    end
    b0 = beatCnt;
    d0 = doneCnt;
    @(posedge clk); #1;
    delta2 = 16'h0155; lr = 16'h0080; b_in = 16'h0123;
    a_in = 64'h0400_FC00_0200_0100;
    w_in = 64'h0010_0200_FF00_0400;
    step = 4'd1;
    startK = cyc;
    pushModel(delta2, lr, a_in, w_in, b_in);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("gate_beat_count", 32'(beatCnt - b0), 32'(N_IN + 1));
    checkOutput("gate_done_count", 32'(doneCnt - d0), 32'd1);
    checkOutput("gate_queue_drained", 32'(expQ.size()), 32'd0);
    controller = 4'd0;

    // Overflow on w0
    $display("[TB] overflow");
    applyStimulus(16'h0200, 16'h0100, A1, W4, 16'h0000);
`ifdef W2UPD_SAT_EN
    pushBeat(0, 0, 16'h8000);
`else
    pushBeat(0, 0, 16'h7F80);
`endif
    pushBeat(1, 0, 16'h0000); pushBeat(2, 0, 16'h0000);
    pushBeat(3, 0, 16'h0000); pushBeat(0, 1, 16'hFF80);
    runOp(0);

    // Reset mid-operation
    $display("[TB] reset mid-op");
    b0 = beatCnt;
    d0 = doneCnt;
    applyStimulus(16'h0200, 16'h0100, A1, W1, 16'h0000);
    pushBeat(0, 0, 16'h0380); pushBeat(1, 0, 16'h0000);
    pushBeat(2, 0, 16'h0000); pushBeat(3, 0, 16'h0000);
    pushBeat(0, 1, 16'hFF80);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      controller = 4'd8;
      if (cyc - startK == 5) break;
    end
    rst = 1'b0;
    expQ.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("abort_beat_count", 32'(beatCnt - b0), 32'd2);
    checkOutput("abort_no_done", 32'(doneCnt - d0), 32'd0);
    acceptCycQ.delete();
    applyStimulus(16'h0200, 16'h0100, A1, W1, 16'h0000);
    pushBeat(0, 0, 16'h0380); pushBeat(1, 0, 16'h0000);
    pushBeat(2, 0, 16'h0000); pushBeat(3, 0, 16'h0000);
    pushBeat(0, 1, 16'hFF80);
    runOp(0);
    for (int j = 0; j < 5; j++) checkOutput($sformatf("rerun_beat%0d_cycle", j), 32'(acceptCycQ[j]), 32'(cycBasic[j]));
    checkOutput("rerun_done_cycle", 32'(lastDoneRel), 32'd11);

    // Randomized operations: random ready, inputs scrambled after start
    $display("[TB] random operations");
    for (int t = 0; t < 8; t++) begin
      logic [15:0] d, l, b;
      logic [N_IN*DW-1:0] a, w;
      d = 16'($urandom);
      l = 16'($urandom);
      b = 16'($urandom);
      a = {$urandom, $urandom};
      w = {$urandom, $urandom};
      if (t < 4) begin
        d = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
        l = 16'($urandom_range(0, 16'h01FF));
      end
      applyStimulus(d, l, a, w, b);
      pushModel(d, l, a, w, b);
      runOp(2);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
